// File: rtl/naive_ntt.sv
// Direct O(N^2) 8-point number-theoretic transform over Z_q, one modular MAC per clock.
// Golden arithmetic reference: 64 RUN cycles per transform, results loaded together at the end.
module naive_ntt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] data_in,
    input  logic [7:0]  omega,
    input  logic [7:0]  mod,
    output logic        busy,
    output logic        done,
    output logic [7:0]  o0,
    output logic [7:0]  o1,
    output logic [7:0]  o2,
    output logic [7:0]  o3,
    output logic [7:0]  o4,
    output logic [7:0]  o5,
    output logic [7:0]  o6,
    output logic [7:0]  o7
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_next;
    logic [63:0] x_r;
    logic [7:0]  omega_r;
    logic [7:0]  q_r;
    logic [2:0]  k, j;
    logic [7:0]  s, t, acc;
    logic [7:0]  res [8];

    logic [7:0]  x_j;
    logic [15:0] prod, ts, so;
    logic [16:0] acc_sum;
    logic [7:0]  acc_next, t_next, s_next, one_q;
    logic        last_term, last_all;

    // Full remainder; a zero modulus collapses every value to 0.
    function automatic logic [7:0] red(input logic [16:0] v, input logic [7:0] q);
        logic [16:0] r;
        if (q == 8'd0) begin
            r = 17'd0;
        end else begin
            r = v % {9'd0, q};
        end
        return r[7:0];
    endfunction

    always_comb begin
        x_j       = x_r[{j, 3'b000} +: 8];
        prod      = x_j * t;
        ts        = t * s;
        so        = s * omega_r;
        acc_sum   = {9'd0, acc} + {1'b0, prod};
        acc_next  = red(acc_sum, q_r);
        t_next    = red({1'b0, ts}, q_r);
        s_next    = red({1'b0, so}, q_r);
        one_q     = red(17'd1, q_r);
        last_term = (j == 3'd7);
        last_all  = last_term && (k == 3'd7);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_all) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r     <= '0;
            omega_r <= '0;
            q_r     <= '0;
            k       <= '0;
            j       <= '0;
            s       <= '0;
            t       <= '0;
            acc     <= '0;
            done    <= 1'b0;
            for (int i = 0; i < 8; i++) res[i] <= '0;
            {o7, o6, o5, o4, o3, o2, o1, o0} <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r     <= data_in;
                        omega_r <= omega;
                        q_r     <= mod;
                        k       <= '0;
                        j       <= '0;
                        acc     <= '0;
                        s       <= red(17'd1, mod);
                        t       <= red(17'd1, mod);
                    end
                end
                RUN: begin
                    j   <= j + 3'd1;
                    acc <= acc_next;
                    t   <= t_next;
                    if (last_term) begin
                        // Close out X_k and step the twiddle base to omega^(k+1).
                        res[k] <= acc_next;
                        acc    <= '0;
                        t      <= one_q;
                        s      <= s_next;
                        k      <= k + 3'd1;
                    end
                    if (last_all) begin
                        o0   <= res[0];
                        o1   <= res[1];
                        o2   <= res[2];
                        o3   <= res[3];
                        o4   <= res[4];
                        o5   <= res[5];
                        o6   <= res[6];
                        o7   <= acc_next;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_naive_ntt.sv
// Scoreboard bench for naive_ntt: directed vectors with hand-computed transforms,
// a monitor that checks results, latency and output hold on every falling edge.
module tb_naive_ntt;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] data_in;
    logic [7:0]  omega;
    logic [7:0]  mod;
    logic        busy;
    logic        done;
    logic [7:0]  o0, o1, o2, o3, o4, o5, o6, o7;
    logic [63:0] outs;

    int          n_cmp;
    int          n_bad;
    int          done_cnt;
    int          cyc;
    logic [63:0] held;
    logic [63:0] exp_q[$];
    int          exp_cyc_q[$];

    localparam logic [63:0] D1   = 64'h0000000002010003;
    localparam logic [63:0] D2   = 64'h0300020100000000;
    localparam logic [63:0] D3   = 64'h0000000000000001;
    localparam logic [63:0] R1   = 64'h030A06020C0B0806;  // 6,8,11,12,2,6,10,3
    localparam logic [63:0] R2   = 64'h0B05050D040E0A06;  // 6,10,14,4,13,5,5,11
    localparam logic [63:0] R3   = 64'h0101010101010101;

    naive_ntt dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .omega   (omega),
        .mod     (mod),
        .busy    (busy),
        .done    (done),
        .o0      (o0),
        .o1      (o1),
        .o2      (o2),
        .o3      (o3),
        .o4      (o4),
        .o5      (o5),
        .o6      (o6),
        .o7      (o7)
    );

    assign outs = {o7, o6, o5, o4, o3, o2, o1, o0};

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    initial begin
        held     = '0;
        done_cnt = 0;
    end
    always @(negedge clk) begin
        if (!rst_n) begin
            held = '0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", {63'd0, done}, 64'd0);
            end else begin
                logic [63:0] e;
                int          ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("result", outs, e);
                check("latency", 64'(cyc), 64'(ec));
                held = e;
            end
            done_cnt++;
        end else begin
            check("hold", outs, held);
        end
    end

    // driver tasks
    task automatic issue(input logic [63:0] d, input logic [7:0] om, input logic [7:0] q,
                         input logic [63:0] exp);
        @(negedge clk);
        data_in = d;
        omega   = om;
        mod     = q;
        start   = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + 64);
        start   = 1'b0;
        data_in = {$urandom, $urandom};
        omega   = 8'($urandom_range(0, 255));
        mod     = 8'($urandom_range(0, 255));
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(input int target);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 150 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) seen = 1'b1;
        end
        check("done_timeout", {63'd0, seen}, 64'd1);
        if (seen) check("busy_at_done", {63'd0, busy}, 64'd0);
    endtask

    task automatic run_vec(input logic [63:0] d, input logic [7:0] om, input logic [7:0] q,
                           input logic [63:0] exp);
        int target;
        target = done_cnt + 1;
        issue(d, om, q, exp);
        wait_done(target);
    endtask

    initial begin
        int target;
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        omega   = '0;
        mod     = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("idle_busy", {63'd0, busy}, 64'd0);
            check("idle_done", {63'd0, done}, 64'd0);
            check("idle_outs", outs, 64'd0);
        end

        run_vec(D1, 8'd15, 8'd17, R1);
        run_vec(D2, 8'd15, 8'd17, R2);

        // extra start pulses and data changes mid-RUN must not disturb the transform
        target = done_cnt + 1;
        issue(D1, 8'd15, 8'd17, R1);
        repeat (10) @(negedge clk);
        start   = 1'b1;
        data_in = D2;
        omega   = 8'd3;
        repeat (10) @(negedge clk);
        start   = 1'b0;
        wait_done(target);
        repeat (5) @(negedge clk);

        // asynchronous reset around cycle 30 of RUN
        issue(D2, 8'd15, 8'd17, R2);
        repeat (29) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        #1;
        check("rst_outs", outs, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_vec(D1, 8'd15, 8'd17, R1);

        // start held high: second transform accepted on the first IDLE edge
        target = done_cnt + 1;
        @(negedge clk);
        data_in = D2;
        omega   = 8'd15;
        mod     = 8'd17;
        start   = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(R2);
        exp_cyc_q.push_back(cyc + 64);
        exp_q.push_back(R2);
        exp_cyc_q.push_back(cyc + 129);
        wait_done(target);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(target + 1);

        // impulse input, then the same with a zero modulus
        run_vec(D3, 8'd15, 8'd17, R3);
        run_vec(D3, 8'd15, 8'd0, 64'd0);
        // modulus 1 and an omega above q
        run_vec(D1, 8'd32, 8'd1, 64'd0);

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
